// File: rtl/riscv_regfile_mp.sv
// Multi-port integer register file with two write ports, optional same-cycle
// write-to-read bypass and a per-register busy scoreboard for long-latency writes.
module riscv_regfile_mp #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NRD*AW-1:0] rd_idx_i,
  output logic [NRD*DW-1:0] rd_data_o,
  output logic [NRD-1:0]    rd_busy_o,
  input  logic              wr0_en_i,
  input  logic [AW-1:0]     wr0_idx_i,
  input  logic [DW-1:0]     wr0_data_i,
  input  logic              wr1_en_i,
  input  logic [AW-1:0]     wr1_idx_i,
  input  logic [DW-1:0]     wr1_data_i,
  input  logic              set_en_i,
  input  logic [AW-1:0]     set_idx_i,
  input  logic              flush_i
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             wr0_act;
  logic             wr1_act;
  logic             set_act;

  // Index 0 is hardwired zero, so every update to it is suppressed here.
  assign wr0_act = wr0_en_i && (wr0_idx_i != '0);
  assign wr1_act = wr1_en_i && (wr1_idx_i != '0);
  assign set_act = set_en_i && (set_idx_i != '0);

  // Later assignments take priority: flush over set over port-1 clear.
  always_comb begin
    busy_nxt = busy;
    if (wr1_act) busy_nxt[wr1_idx_i] = 1'b0;
    if (set_act) busy_nxt[set_idx_i] = 1'b1;
    if (flush_i) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy <= '0;
    end else begin
      if (wr0_act) mem[wr0_idx_i] <= wr0_data_i;
      // Port 1 is assigned last so it wins a same-index collision.
      if (wr1_act) mem[wr1_idx_i] <= wr1_data_i;
      busy <= busy_nxt;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] r;
    logic          hit0;
    logic          hit1;
    logic [DW-1:0] data;

    assign r    = rd_idx_i[k*AW +: AW];
    assign hit0 = (BYPASS != 0) && wr0_act && (wr0_idx_i == r);
    assign hit1 = (BYPASS != 0) && wr1_act && (wr1_idx_i == r);

    always_comb begin
      data = mem[r];
      if (hit0) data = wr0_data_i;
      if (hit1) data = wr1_data_i;
      if (r == '0) data = '0;
    end

    assign rd_data_o[k*DW +: DW] = data;
    assign rd_busy_o[k]          = (r != '0) && busy[r] && !hit1;
  end

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Bench for riscv_regfile_mp: a bypassing and a non-bypassing instance share
// stimulus and are compared against an array-based model of the register file.
module tb_riscv_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NRD = 3;
  localparam int N = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD*AW-1:0] rd_idx;
  logic [NRD*DW-1:0] rd_data1, rd_data0;
  logic [NRD-1:0]    rd_busy1, rd_busy0;
  logic              wr0_en, wr1_en, set_en, flush;
  logic [AW-1:0]     wr0_idx, wr1_idx, set_idx;
  logic [DW-1:0]     wr0_data, wr1_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] m_mem [N];
  bit            m_busy [N];

  always #5 clk = ~clk;

  riscv_regfile_mp #(.DW(DW), .AW(AW), .NRD(NRD), .BYPASS(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .rd_idx_i(rd_idx), .rd_data_o(rd_data1), .rd_busy_o(rd_busy1),
    .wr0_en_i(wr0_en), .wr0_idx_i(wr0_idx), .wr0_data_i(wr0_data),
    .wr1_en_i(wr1_en), .wr1_idx_i(wr1_idx), .wr1_data_i(wr1_data),
    .set_en_i(set_en), .set_idx_i(set_idx), .flush_i(flush));

  riscv_regfile_mp #(.DW(DW), .AW(AW), .NRD(NRD), .BYPASS(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .rd_idx_i(rd_idx), .rd_data_o(rd_data0), .rd_busy_o(rd_busy0),
    .wr0_en_i(wr0_en), .wr0_idx_i(wr0_idx), .wr0_data_i(wr0_data),
    .wr1_en_i(wr1_en), .wr1_idx_i(wr1_idx), .wr1_data_i(wr1_data),
    .set_en_i(set_en), .set_idx_i(set_idx), .flush_i(flush));

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected read value: register 0 is zero; with bypass, a write to the
  // register this cycle (port 1 preferred) is visible; otherwise stored value.
  function automatic logic [DW-1:0] exp_data(input bit bp, input int r);
    if (r == 0) return '0;
    if (bp && wr1_en && int'(wr1_idx) == r) return wr1_data;
    if (bp && wr0_en && int'(wr0_idx) == r) return wr0_data;
    return m_mem[r];
  endfunction

  function automatic logic exp_busy(input bit bp, input int r);
    if (r == 0) return 1'b0;
    if (bp && wr1_en && int'(wr1_idx) == r) return 1'b0;
    return m_busy[r];
  endfunction

  function automatic int port_idx(input int k);
    return int'(rd_idx[k*AW +: AW]);
  endfunction

  task automatic check_all();
    for (int k = 0; k < NRD; k++) begin
      int r;
      r = port_idx(k);
      chk($sformatf("bp1_p%0d_r%0d_data", k, r), rd_data1[k*DW +: DW], exp_data(1'b1, r));
      chk($sformatf("bp1_p%0d_r%0d_busy", k, r), {31'b0, rd_busy1[k]}, {31'b0, exp_busy(1'b1, r)});
      chk($sformatf("bp0_p%0d_r%0d_data", k, r), rd_data0[k*DW +: DW], exp_data(1'b0, r));
      chk($sformatf("bp0_p%0d_r%0d_busy", k, r), {31'b0, rd_busy0[k]}, {31'b0, exp_busy(1'b0, r)});
    end
  endtask

  // Model state update at a rising edge, written from the register-file rules.
  task automatic model_edge();
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        m_mem[i] = '0;
        m_busy[i] = 1'b0;
      end
      return;
    end
    for (int i = 1; i < N; i++) begin
      if (flush)                           m_busy[i] = 1'b0;
      else if (set_en && int'(set_idx) == i) m_busy[i] = 1'b1;
      else if (wr1_en && int'(wr1_idx) == i) m_busy[i] = 1'b0;
    end
    if (wr0_en && wr0_idx != 0) m_mem[wr0_idx] = wr0_data;
    if (wr1_en && wr1_idx != 0) m_mem[wr1_idx] = wr1_data;
  endtask

  task automatic cycle(input bit do_check);
    #1;
    if (do_check) check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr0_en = 0; wr1_en = 0; set_en = 0; flush = 0;
    wr0_idx = '0; wr1_idx = '0; set_idx = '0;
    wr0_data = '0; wr1_data = '0;
  endtask

  task automatic read_all(input int r);
    for (int k = 0; k < NRD; k++) rd_idx[k*AW +: AW] = AW'(r);
  endtask

  task automatic randomize_inputs(input int span);
    wr0_en = $urandom_range(0, 1);
    wr1_en = $urandom_range(0, 1);
    set_en = $urandom_range(0, 2) == 0;
    flush  = $urandom_range(0, 15) == 0;
    rst    = $urandom_range(0, 63) != 0;
    wr0_idx = AW'($urandom_range(0, span));
    wr1_idx = AW'($urandom_range(0, span));
    set_idx = AW'($urandom_range(0, span));
    wr0_data = $urandom;
    wr1_data = $urandom;
    for (int k = 0; k < NRD; k++) rd_idx[k*AW +: AW] = AW'($urandom_range(0, span));
  endtask

  initial begin
    idle();
    rst = 1'b0;
    rd_idx = '0;
    wr0_en = 1; wr0_idx = 5'd4; wr0_data = 32'hCAFE0001;
    cycle(1'b0);
    idle();
    cycle(1'b0);
    rst = 1'b1;

    // Reset state on every index and port, then writes to r0 are ignored.
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < NRD; k++) rd_idx[k*AW +: AW] = AW'((i + k) % N);
      #1;
      check_all();
      chk($sformatf("reset_r%0d", i), rd_data0[DW-1:0], 32'h0);
    end
    read_all(0);
    wr0_en = 1; wr0_idx = 0; wr0_data = 32'hDEADBEEF;
    wr1_en = 1; wr1_idx = 0; wr1_data = 32'hDEADBEEF;
    set_en = 1; set_idx = 0;
    cycle(1'b1);
    idle();
    cycle(1'b1);
    chk("r0_after_write", rd_data1[DW-1:0], 32'h0);

    // Port-0 write with same-cycle read: bypass vs array.
    read_all(5);
    wr0_en = 1; wr0_idx = 5; wr0_data = 32'h12345678;
    #1;
    chk("r5_bypass", rd_data1[DW-1:0], 32'h12345678);
    chk("r5_nobypass", rd_data0[DW-1:0], 32'h0);
    cycle(1'b1);
    idle();
    cycle(1'b1);
    chk("r5_after", rd_data0[DW-1:0], 32'h12345678);

    // Both ports hit r7: port 1 wins.
    read_all(7);
    wr0_en = 1; wr0_idx = 7; wr0_data = 32'hAAAA0000;
    wr1_en = 1; wr1_idx = 7; wr1_data = 32'h5555FFFF;
    #1;
    chk("r7_bypass", rd_data1[DW-1:0], 32'h5555FFFF);
    cycle(1'b1);
    idle();
    cycle(1'b1);
    chk("r7_stored", rd_data0[DW-1:0], 32'h5555FFFF);

    // Scoreboard on r9.
    read_all(9);
    set_en = 1; set_idx = 9;
    #1;
    chk("r9_set_same_cycle", {31'b0, rd_busy1[0]}, 32'h0);
    cycle(1'b1);
    idle();
    cycle(1'b1);
    chk("r9_busy", {29'b0, rd_busy1}, 32'h7);
    wr0_en = 1; wr0_idx = 9; wr0_data = 32'h77;
    cycle(1'b1);
    idle();
    chk("r9_busy_after_p0", {29'b0, rd_busy0}, 32'h7);
    wr1_en = 1; wr1_idx = 9; wr1_data = 32'h1;
    #1;
    chk("r9_clear_bp1", {29'b0, rd_busy1}, 32'h0);
    chk("r9_clear_bp0", {29'b0, rd_busy0}, 32'h7);
    cycle(1'b1);
    idle();
    cycle(1'b1);
    chk("r9_data", rd_data0[DW-1:0], 32'h1);

    // Set beats same-cycle clear; flush beats same-cycle set.
    read_all(3);
    set_en = 1; set_idx = 3;
    wr1_en = 1; wr1_idx = 3; wr1_data = 32'h33;
    cycle(1'b1);
    idle();
    cycle(1'b1);
    chk("r3_set_wins", {31'b0, rd_busy0[0]}, 32'h1);
    set_en = 1; set_idx = 4;
    cycle(1'b1);
    set_idx = 6; flush = 1;
    cycle(1'b1);
    idle();
    for (int i = 0; i < N; i++) begin
      read_all(i);
      #1;
      check_all();
      chk($sformatf("flush_r%0d", i), {31'b0, rd_busy1[0]}, 32'h0);
    end

    // Fill r1..r31 with a reset pulse mid-stream while writes are active.
    for (int i = 1; i < N; i++) begin
      wr0_en = 1; wr0_idx = AW'(i); wr0_data = 32'h1000_0000 + i;
      set_en = 1; set_idx = AW'(i);
      rst = (i != 16);
      for (int k = 0; k < NRD; k++) rd_idx[k*AW +: AW] = AW'((i + k * 7) % N);
      cycle(1'b1);
    end
    idle();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      read_all(i);
      #1;
      check_all();
    end
    read_all(10);
    #1;
    chk("r10_cleared_by_reset", rd_data0[DW-1:0], 32'h0);
    read_all(20);
    #1;
    chk("r20_written_after_reset", rd_data0[DW-1:0], 32'h1000_0014);

    // Randomized traffic: tight index range first for collisions, then full range.
    for (int n = 0; n < 400; n++) begin
      randomize_inputs(7);
      cycle(1'b1);
    end
    for (int n = 0; n < 400; n++) begin
      randomize_inputs(N - 1);
      cycle(1'b1);
    end
    idle();
    rst = 1'b1;
    cycle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/riscv_regfile_mp.md
# riscv_regfile_mp

Parametrised multi-port integer register file with a write-back scoreboard. It sits between decode and execute/write-back in the core. It provides `NRD` combinational read ports and two synchronous write ports: port 0 for the ALU result and port 1 for load/late results. Optional same-cycle write-to-read bypass is selected by parameter. Per-register busy bits track outstanding long-latency writes, so issue logic can stall on hazards.

## Interface
- `DW`, 32: data width in bits.
- `AW`, 5: index width; depth is 2^AW registers; register 0 is hardwired zero.
- `NRD`, 2: number of read ports, from 1 to 4.
- `BYPASS`, 1: 1 means reads see same-cycle write data; 0 means reads see array contents only.
- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `rst_i`  in  1  reset, synchronous, active-low (0 = reset).
- `rd_idx_i`  in  NRD*AW  read indices; port k occupies bits [k*AW +: AW].
- `rd_data_o`  out  NRD*DW  read data; port k occupies bits [k*DW +: DW].
- `rd_busy_o`  out  NRD  1 means the register read on port k has an outstanding write.
- `wr0_en_i`  in  1  write enable, port 0.
- `wr0_idx_i`  in  AW  write index, port 0.
- `wr0_data_i`  in  DW  write data, port 0.
- `wr1_en_i`  in  1  write enable, port 1; also clears the busy bit of its index.
- `wr1_idx_i`  in  AW  write index, port 1.
- `wr1_data_i`  in  DW  write data, port 1.
- `set_en_i`  in  1  marks `set_idx_i` busy (long-latency instruction issued).
- `set_idx_i`  in  AW  index to mark busy.
- `flush_i`  in  1  clears all busy bits (pipeline flush); does not touch data.

## Operation
- Storage:
  - 2^AW x DW data array.
  - 2^AW busy bits.
  - Register 0 is never stored: it always reads 0 and its busy bit always reads 0.
  - Writes and sets to index 0 are ignored.
- Write, port 0: when `wr0_en_i`=1 and `wr0_idx_i`≠0, the register takes `wr0_data_i` at the edge.
- Write, port 1: when `wr1_en_i`=1 and `wr1_idx_i`≠0:
  - the register takes `wr1_data_i` at the edge;
  - busy[`wr1_idx_i`] is cleared.
- Both ports enabled with the same nonzero index: port 1 data is stored and port 0 is discarded.
- Scoreboard, next state of busy[i], evaluated in this priority order (earliest wins):
  - reset → 0;
  - `flush_i` → 0, overriding any set in the same cycle;
  - `set_en_i` and i=`set_idx_i` → 1, so a set wins over a same-cycle port-1 clear of the same index;
  - `wr1_en_i` and i=`wr1_idx_i` → 0;
  - otherwise the bit holds.
- Port 0 writes never change busy bits.
- Read, per port k with index r:
  - r=0 → data 0, busy 0.
  - BYPASS=1:
    - data comes from port 1 if it writes r this cycle;
    - else from port 0 if it writes r this cycle;
    - else from the array.
  - BYPASS=1, busy: `rd_busy_o`[k] = busy[r] AND NOT (`wr1_en_i` and `wr1_idx_i`=r).
  - BYPASS=0: data comes from the array and `rd_busy_o`[k] = busy[r].
- `set_en_i` does not affect same-cycle read outputs.
- Read ports are fully independent; any number of ports may read the same index.

## Timing
- Read path is combinational, with zero-cycle latency from `rd_idx_i` and the write inputs.
- A write at edge N is visible in the array from edge N onward:
  - BYPASS=0: a same-index read in the cycle before edge N returns the old value.
  - BYPASS=1: the same read returns the new value.
- Busy set at edge N: `rd_busy_o` is 1 from edge N onward until the clearing port-1 write.
  - BYPASS=1: busy reads 0 already in the clearing cycle.
  - BYPASS=0: busy reads 0 from the following edge.
- Reset (`rst_i`=0 sampled at an edge):
  - all data registers become 0 and all busy bits become 0;
  - writes, sets and flush in that cycle are ignored.
- Reset outputs:
  - after reset, `rd_data_o` is all 0 and `rd_busy_o` is all 0;
  - exception: while reset is held with BYPASS=1, the combinational bypass still reflects active write inputs.
- Reset mid-operation discards all pending busy state. No X may propagate from the uninitialised array, because reset zeroes every entry.

## Test plan
- Reset, then read all indices on every port → data 0x00000000, busy 0; write r0 with 0xDEADBEEF → r0 still reads 0.
- Port 0 writes r5=0x12345678 while port 0 of the read side reads r5 in the same cycle → BYPASS=1: 0x12345678 the same cycle; BYPASS=0: old value 0, then 0x12345678 after the edge.
- Both write ports target r7 in one cycle (port 0 writes 0xAAAA0000, port 1 writes 0x5555FFFF) → r7=0x5555FFFF, and bypass also shows 0x5555FFFF.
- Scoreboard sequence on r9:
  - set r9 → busy=1 on every port reading r9;
  - port-0 write to r9 → busy stays 1;
  - port-1 write r9=0x1 → busy=0 (same cycle with BYPASS=1) and data=0x1.
- Set and port-1 clear of r3 in the same cycle → busy[r3]=1; set r3 and r4, then `flush_i` together with a set of r6 → all busy bits are 0.
- Write r1..r31 with distinct values, assert `rst_i`=0 for one cycle mid-stream with writes active → all reads return 0 and busy 0; the next writes proceed normally.
